// File: rtl/disparity_pkg.sv
// rtl/disparity_pkg.sv - shared state encoding, colour map and clog2 helper for the disparity engine
package disparity_pkg;

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_CALC   = 2'd1;
    localparam logic [1:0] ST_OUTPUT = 2'd2;

    // Colour map packed as {R, G, B}, 10 bits per channel.
    localparam logic [29:0] CMAP_0 = {10'd255, 10'd0,   10'd0};
    localparam logic [29:0] CMAP_1 = {10'd255, 10'd64,  10'd0};
    localparam logic [29:0] CMAP_2 = {10'd255, 10'd136, 10'd0};
    localparam logic [29:0] CMAP_3 = {10'd255, 10'd221, 10'd0};
    localparam logic [29:0] CMAP_4 = {10'd153, 10'd255, 10'd0};
    localparam logic [29:0] CMAP_5 = {10'd26,  10'd255, 10'd0};
    localparam logic [29:0] CMAP_6 = {10'd0,   10'd255, 10'd162};
    localparam logic [29:0] CMAP_7 = {10'd0,   10'd212, 10'd255};
    localparam logic [29:0] CMAP_8 = {10'd0,   10'd98,  10'd255};
    localparam logic [29:0] CMAP_9 = {10'd47,  10'd0,   10'd255};

    // Ceiling log2, never below 1 so that derived vector widths stay legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

    function automatic logic [29:0] cmap(input int d);
        case (d)
            0:       return CMAP_0;
            1:       return CMAP_1;
            2:       return CMAP_2;
            3:       return CMAP_3;
            4:       return CMAP_4;
            5:       return CMAP_5;
            6:       return CMAP_6;
            7:       return CMAP_7;
            8:       return CMAP_8;
            default: return CMAP_9;
        endcase
    endfunction

endpackage

// File: rtl/disparity_cost.sv
// rtl/disparity_cost.sv - combinational WIN-lane sum of absolute differences
// Ports: r_win/l_win - WIN packed pixels (lane k at bits k*PIX_W), cost - SAD result
module disparity_cost
    import disparity_pkg::*;
#(
    parameter int PIX_W = 9,
    parameter int WIN   = 4
) (
    input  logic [WIN*PIX_W-1:0]            r_win,
    input  logic [WIN*PIX_W-1:0]            l_win,
    output logic [PIX_W+clog2(WIN)-1:0]     cost
);

    localparam int COST_W = PIX_W + clog2(WIN);

    logic [PIX_W-1:0] a;
    logic [PIX_W-1:0] b;
    logic [PIX_W-1:0] diff;

    always_comb begin
        cost = '0;
        a    = '0;
        b    = '0;
        diff = '0;
        for (int k = 0; k < WIN; k++) begin
            a    = r_win[k*PIX_W +: PIX_W];
            b    = l_win[k*PIX_W +: PIX_W];
            diff = (a > b) ? (a - b) : (b - a);
            cost = cost + COST_W'(diff);
        end
    end

endmodule

// File: rtl/disparity_engine.sv
// rtl/disparity_engine.sv - line-based block-matching disparity engine (FETCH/CALC/OUTPUT)
// Ports: clk, rst_n (sync, active-low); i_valid_l/i_data_l/o_ready_l and
//        i_valid_r/i_data_r/o_ready_r - left/right pixel inputs; o_valid/i_ready -
//        output handshake; o_disp - block disparity; o_data_R/G/B - display colour;
//        o_busy - high outside FETCH.
// Build option: DISP_COLOR_EN selects the colour map, otherwise grayscale.
module disparity_engine
    import disparity_pkg::*;
#(
    parameter int PIX_W    = 9,
    parameter int LINE_W   = 800,
    parameter int WIN      = 4,
    parameter int MAX_DISP = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_valid_l,
    input  logic                        i_valid_r,
    input  logic [PIX_W-1:0]            i_data_l,
    input  logic [PIX_W-1:0]            i_data_r,
    output logic                        o_ready_l,
    output logic                        o_ready_r,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [clog2(MAX_DISP)-1:0]  o_disp,
    output logic [9:0]                  o_data_R,
    output logic [9:0]                  o_data_G,
    output logic [9:0]                  o_data_B,
    output logic                        o_busy
);

    localparam int NB     = LINE_W / WIN;
    localparam int DISP_W = clog2(MAX_DISP);
    localparam int COST_W = PIX_W + clog2(WIN);
    localparam int CNT_W  = clog2(LINE_W + 1);
    localparam int IDX_W  = clog2(LINE_W);
    localparam int NB_W   = clog2(NB);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt_l;
    logic [CNT_W-1:0]   cnt_r;
    logic [NB_W-1:0]    b_cnt;
    logic [DISP_W-1:0]  d_cnt;
    logic [IDX_W-1:0]   out_cnt;
    logic [COST_W-1:0]  min_cost;
    logic [DISP_W-1:0]  best_d;

    logic [PIX_W-1:0]   l_buf   [LINE_W];
    logic [PIX_W-1:0]   r_buf   [LINE_W];
    logic [DISP_W-1:0]  res_buf [NB];

    logic [WIN*PIX_W-1:0] r_win;
    logic [WIN*PIX_W-1:0] l_win;
    logic [COST_W-1:0]    cost;
    logic                 pair_valid;
    logic                 better;
    logic [DISP_W-1:0]    new_best;
    logic                 acc_l;
    logic                 acc_r;
    logic                 lines_full;
    logic                 d_last;
    logic                 b_last;
    logic                 out_last;
    logic [NB_W-1:0]      out_blk;
    int                   base;
    int                   l_idx;

    assign o_ready_l  = (state == ST_FETCH) && (cnt_l < CNT_W'(LINE_W));
    assign o_ready_r  = (state == ST_FETCH) && (cnt_r < CNT_W'(LINE_W));
    assign acc_l      = o_ready_l && i_valid_l;
    assign acc_r      = o_ready_r && i_valid_r;
    assign lines_full = (cnt_l == CNT_W'(LINE_W)) && (cnt_r == CNT_W'(LINE_W));
    assign d_last     = (d_cnt == DISP_W'(MAX_DISP - 1));
    assign b_last     = (b_cnt == NB_W'(NB - 1));
    assign out_last   = (out_cnt == IDX_W'(LINE_W - 1));
    assign out_blk    = NB_W'(int'(out_cnt) / WIN);

    // Gather the right window for block b and the left window shifted by d.
    // Out-of-line left indices are redirected to 0; such pairs are invalid
    // and their cost is discarded.
    always_comb begin
        r_win      = '0;
        l_win      = '0;
        base       = int'(b_cnt) * WIN;
        l_idx      = 0;
        pair_valid = (base + WIN - 1 + int'(d_cnt)) < LINE_W;
        for (int k = 0; k < WIN; k++) begin
            r_win[k*PIX_W +: PIX_W] = r_buf[IDX_W'(base + k)];
            l_idx = base + k + int'(d_cnt);
            if (l_idx >= LINE_W) begin
                l_idx = 0;
            end
            l_win[k*PIX_W +: PIX_W] = l_buf[IDX_W'(l_idx)];
        end
    end

    disparity_cost #(
        .PIX_W (PIX_W),
        .WIN   (WIN)
    ) u_cost (
        .r_win (r_win),
        .l_win (l_win),
        .cost  (cost)
    );

    // Strict compare keeps the smallest d on ties. The minimum restarts at
    // all-ones, above any reachable cost, so d=0 always wins first.
    assign better   = pair_valid && (cost < min_cost);
    assign new_best = better ? d_cnt : best_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            cnt_l    <= '0;
            cnt_r    <= '0;
            b_cnt    <= '0;
            d_cnt    <= '0;
            out_cnt  <= '0;
            min_cost <= '1;
            best_d   <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (acc_l) begin
                        cnt_l <= cnt_l + 1'b1;
                    end
                    if (acc_r) begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                    if (lines_full) begin
                        state <= ST_CALC;
                        cnt_l <= '0;
                        cnt_r <= '0;
                    end
                end
                ST_CALC: begin
                    if (d_last) begin
                        min_cost <= '1;
                        best_d   <= '0;
                        d_cnt    <= '0;
                        if (b_last) begin
                            b_cnt <= '0;
                            state <= ST_OUTPUT;
                        end else begin
                            b_cnt <= b_cnt + 1'b1;
                        end
                    end else begin
                        d_cnt <= d_cnt + 1'b1;
                        if (better) begin
                            min_cost <= cost;
                            best_d   <= d_cnt;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (i_ready) begin
                        if (out_last) begin
                            out_cnt <= '0;
                            state   <= ST_FETCH;
                        end else begin
                            out_cnt <= out_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

    // Storage arrays carry no reset; contents are rewritten every line.
    always_ff @(posedge clk) begin
        if (acc_l) begin
            l_buf[IDX_W'(cnt_l)] <= i_data_l;
        end
        if (acc_r) begin
            r_buf[IDX_W'(cnt_r)] <= i_data_r;
        end
        if ((state == ST_CALC) && d_last) begin
            res_buf[b_cnt] <= new_best;
        end
    end

    assign o_busy  = (state != ST_FETCH);
    assign o_valid = (state == ST_OUTPUT);
    assign o_disp  = o_valid ? res_buf[out_blk] : '0;

`ifdef DISP_COLOR_EN
    logic [29:0] rgb;
    assign rgb      = o_valid ? cmap(int'(o_disp)) : '0;
    assign o_data_R = rgb[29:20];
    assign o_data_G = rgb[19:10];
    assign o_data_B = rgb[9:0];
`else
    localparam int GRAY_SH = 10 - DISP_W;
    logic [9:0] gray;
    assign gray     = 10'(o_disp) << GRAY_SH;
    assign o_data_R = gray;
    assign o_data_G = gray;
    assign o_data_B = gray;
`endif

endmodule

// File: tb/tb_disparity_engine.sv
// tb/tb_disparity_engine.sv - randomized self-checking bench for disparity_engine
module tb_disparity_engine;

    localparam int PIX_W    = 9;
    localparam int LINE_W   = 16;
    localparam int WIN      = 4;
    localparam int MAX_DISP = 4;
    localparam int DISP_W   = 2;
    localparam int NB       = LINE_W / WIN;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_valid_l, i_valid_r;
    logic [PIX_W-1:0]  i_data_l, i_data_r;
    logic              o_ready_l, o_ready_r;
    logic              o_valid;
    logic              i_ready;
    logic [DISP_W-1:0] o_disp;
    logic [9:0]        o_data_R, o_data_G, o_data_B;
    logic              o_busy;

    always #5 clk = ~clk;

    disparity_engine #(
        .PIX_W    (PIX_W),
        .LINE_W   (LINE_W),
        .WIN      (WIN),
        .MAX_DISP (MAX_DISP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid_l (i_valid_l),
        .i_valid_r (i_valid_r),
        .i_data_l  (i_data_l),
        .i_data_r  (i_data_r),
        .o_ready_l (o_ready_l),
        .o_ready_r (o_ready_r),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_disp    (o_disp),
        .o_data_R  (o_data_R),
        .o_data_G  (o_data_G),
        .o_data_B  (o_data_B),
        .o_busy    (o_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int lpix [LINE_W];
    int rpix [LINE_W];
    int exp_d [NB];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: for each block pick the lowest-cost shift among shifts whose
    // window stays inside the line, earliest shift winning ties.
    function automatic void model();
        for (int b = 0; b < NB; b++) begin
            int best_c;
            best_c   = -1;
            exp_d[b] = 0;
            for (int d = 0; d < MAX_DISP; d++) begin
                int c;
                if (b*WIN + WIN - 1 + d < LINE_W) begin
                    c = 0;
                    for (int k = 0; k < WIN; k++) begin
                        int df;
                        df = rpix[b*WIN+k] - lpix[b*WIN+k+d];
                        c += (df < 0) ? -df : df;
                    end
                    if (best_c < 0 || c < best_c) begin
                        best_c   = c;
                        exp_d[b] = d;
                    end
                end
            end
        end
    endfunction

    function automatic logic [29:0] rgb_of(input int d);
`ifdef DISP_COLOR_EN
        int tab [10][3] = '{'{255,0,0}, '{255,64,0}, '{255,136,0}, '{255,221,0}, '{153,255,0},
                            '{26,255,0}, '{0,255,162}, '{0,212,255}, '{0,98,255}, '{47,0,255}};
        int i;
        i = (d > 9) ? 9 : d;
        return {10'(tab[i][0]), 10'(tab[i][1]), 10'(tab[i][2])};
`else
        int g;
        g = d * (1024 / (1 << DISP_W));
        return {10'(g), 10'(g), 10'(g)};
`endif
    endfunction

    // mode 0: both sides random-valid together; mode 1: all left, then all right.
    task automatic feed(input int mode);
        int il, ir, guard, rd_err;
        logic vl, vr, al, ar;
        il = 0; ir = 0; guard = 0; rd_err = 0;
        while ((il < LINE_W || ir < LINE_W) && guard < 1000) begin
            guard++;
            if (o_ready_l !== (il < LINE_W)) rd_err++;
            if (o_ready_r !== (ir < LINE_W)) rd_err++;
            vl = (il < LINE_W) && (mode == 1 || $urandom_range(0, 3) != 0);
            vr = (ir < LINE_W) && ((mode == 1) ? (il >= LINE_W) : ($urandom_range(0, 3) != 0));
            i_valid_l = vl;
            i_valid_r = vr;
            i_data_l  = vl ? PIX_W'(lpix[il]) : PIX_W'($urandom);
            i_data_r  = vr ? PIX_W'(rpix[ir]) : PIX_W'($urandom);
            al = vl && o_ready_l;
            ar = vr && o_ready_r;
            @(posedge clk);
            if (al) il++;
            if (ar) ir++;
            @(negedge clk);
        end
        i_valid_l = 1'b0;
        i_valid_r = 1'b0;
        check("feed_done", (il == LINE_W && ir == LINE_W), 1);
        check("ready_track", rd_err, 0);
        check("pre_calc_busy", o_busy, 0);
        check("pre_calc_ready", {o_ready_l, o_ready_r}, 0);
        @(negedge clk);
        check("calc_start", o_busy, 1);
    endtask

    task automatic measure_calc();
        int cyc, rd_err;
        cyc = 0; rd_err = 0;
        while (!o_valid && cyc < 100) begin
            cyc++;
            if (o_ready_l !== 1'b0 || o_ready_r !== 1'b0) rd_err++;
            i_valid_l = 1'($urandom);
            i_valid_r = 1'($urandom);
            @(negedge clk);
        end
        check("calc_len", cyc, LINE_W / WIN * MAX_DISP);
        check("calc_ready_low", rd_err, 0);
    endtask

    task automatic drain(input int stall_px, input int rnd);
        int p, cyc, stall_left, v_err, rd_err;
        logic rdy;
        p = 0; cyc = 0; stall_left = 5; v_err = 0; rd_err = 0;
        while (p < LINE_W && cyc < 500) begin
            cyc++;
            if (o_valid !== 1'b1) v_err++;
            if (o_ready_l !== 1'b0 || o_ready_r !== 1'b0) rd_err++;
            if (p == stall_px && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
                check("stall_hold", {o_valid, o_disp}, {1'b1, DISP_W'(exp_d[p / WIN])});
            end else begin
                rdy = (rnd != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            i_ready   = rdy;
            i_valid_l = 1'($urandom);
            i_valid_r = 1'($urandom);
            if (o_valid && rdy) begin
                check("disp", o_disp, exp_d[p / WIN]);
                check("rgb", {o_data_R, o_data_G, o_data_B}, rgb_of(exp_d[p / WIN]));
                p++;
            end
            @(negedge clk);
        end
        i_ready   = 1'b0;
        i_valid_l = 1'b0;
        i_valid_r = 1'b0;
        check("out_count", p, LINE_W);
        check("valid_held", v_err, 0);
        check("out_ready_low", rd_err, 0);
        check("return_valid", o_valid, 0);
        check("return_busy", o_busy, 0);
    endtask

    task automatic run_line(input int mode, input int stall_px, input int rnd);
        model();
        feed(mode);
        measure_calc();
        drain(stall_px, rnd);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_ready"}, {o_ready_l, o_ready_r}, 2'b11);
        check({tag, "_disp"}, o_disp, 0);
        check({tag, "_rgb"}, {o_data_R, o_data_G, o_data_B}, 0);
    endtask

    initial begin
        rst_n = 1'b0; i_valid_l = 1'b0; i_valid_r = 1'b0;
        i_data_l = '0; i_data_r = '0; i_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        // Identical ramps.
        for (int x = 0; x < LINE_W; x++) begin lpix[x] = 10 * x; rpix[x] = 10 * x; end
        run_line(0, -1, 1);

        // Left is the right ramp shifted by two; left-then-right fill.
        for (int x = 0; x < LINE_W; x++) begin
            rpix[x] = 7 * x + 3;
            lpix[x] = (x < 2) ? 0 : 7 * (x - 2) + 3;
        end
        run_line(1, -1, 0);

        // Flat lines: all costs tie.
        for (int x = 0; x < LINE_W; x++) begin lpix[x] = 100; rpix[x] = 100; end
        run_line(0, -1, 1);

        // Shifted ramp again with a five-cycle stall at pixel 6.
        for (int x = 0; x < LINE_W; x++) begin
            rpix[x] = 7 * x + 3;
            lpix[x] = (x < 2) ? 0 : 7 * (x - 2) + 3;
        end
        run_line(0, 6, 0);

        // Random shifted and fully random lines.
        for (int t = 0; t < 4; t++) begin
            int ds;
            ds = $urandom_range(0, MAX_DISP - 1);
            for (int x = 0; x < LINE_W; x++) rpix[x] = $urandom_range(0, 511);
            for (int x = 0; x < LINE_W; x++)
                lpix[x] = (t < 2 && x >= ds) ? rpix[x - ds] : $urandom_range(0, 511);
            run_line(t % 2, (t == 3) ? $urandom_range(0, LINE_W - 1) : -1, 1);
        end

        // Reset in the middle of CALC, then a clean line.
        for (int x = 0; x < LINE_W; x++) begin rpix[x] = $urandom_range(0, 511); lpix[x] = $urandom_range(0, 511); end
        model();
        feed(0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle("mid_rst");
        for (int x = 0; x < LINE_W; x++) begin rpix[x] = 5 * x + 40; lpix[x] = (x < 1) ? 0 : 5 * (x - 1) + 40; end
        run_line(0, -1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
